// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared widths, queue depth and FSM encoding for the fetch sequencer
package fetch_sequencer_pkg;

    localparam int DEF_ISIZE  = 16;
    localparam int DEF_IWIDTH = 16;
    localparam int QDEPTH     = 2;

    // Queue occupancy is 0..2, so two bits are enough.
    localparam int             CNT_W  = 2;
    localparam logic [CNT_W-1:0] Q_FULL = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_queue.sv
// rtl/fetch_sequencer_queue.sv - 2-entry FIFO of {pc, instr} between fetch and decode
module fetch_queue
    import fetch_sequencer_pkg::*;
#(
    parameter int AW = DEF_ISIZE,
    parameter int DW = DEF_IWIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [AW-1:0]    push_pc,
    input  logic [DW-1:0]    push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic [AW-1:0]    head_pc,
    output logic [DW-1:0]    head_data
);

    // Entry 0 is always the oldest; entry 1 only holds data when count is 2.
    logic [AW-1:0]    pc0_q, pc0_d, pc1_q, pc1_d;
    logic [DW-1:0]    data0_q, data0_d, data1_q, data1_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    // Guard against pops from empty and pushes into full so count can never wrap.
    assign push_ok = push && (count_q != Q_FULL);
    assign pop_ok  = pop && (count_q != '0);

    // Next-state: flush wins, otherwise shift on pop and append behind the survivors on push.
    always_comb begin
        pc0_d   = pc0_q;
        pc1_d   = pc1_q;
        data0_d = data0_q;
        data1_d = data1_q;
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (count_q == '0) begin
                        pc0_d   = push_pc;
                        data0_d = push_data;
                    end else begin
                        pc1_d   = push_pc;
                        data1_d = push_data;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    pc0_d   = pc1_q;
                    data0_d = data1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == Q_FULL) begin
                        pc0_d   = pc1_q;
                        data0_d = data1_q;
                        pc1_d   = push_pc;
                        data1_d = push_data;
                    end else begin
                        pc0_d   = push_pc;
                        data0_d = push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage registers, cleared on reset so the head presents zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc0_q   <= '0;
            pc1_q   <= '0;
            data0_q <= '0;
            data1_q <= '0;
            count_q <= '0;
        end else begin
            pc0_q   <= pc0_d;
            pc1_q   <= pc1_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            count_q <= count_d;
        end
    end

    assign count     = count_q;
    assign head_pc   = pc0_q;
    assign head_data = data0_q;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch FSM with redirect/kill and next_pc generation
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int ISIZE  = DEF_ISIZE,
    parameter int IWIDTH = DEF_IWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ISIZE-1:0]  curr_pc,
    output logic [ISIZE-1:0]  next_pc,
    output logic              imem_req,
    output logic [ISIZE-1:0]  imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [IWIDTH-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [ISIZE-1:0]  redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [IWIDTH-1:0] inst_data,
    output logic [ISIZE-1:0]  inst_pc
);

    fetch_state_e     state_q, state_d;
    logic             kill_q, kill_d;
    logic [ISIZE-1:0] pend_pc_q, pend_pc_d;
    logic [CNT_W-1:0] q_count;
    logic             q_push, q_pop;
    logic             granted;

    assign granted = imem_req && imem_gnt;

    // Redirect beats everything; a grant advances the PC by one word, wrapping naturally.
    assign next_pc   = redirect ? redirect_pc :
                       granted  ? curr_pc + ISIZE'(1) : curr_pc;
    assign imem_addr = imem_req ? curr_pc : '0;

    // A pop in a redirect cycle is meaningless because the queue is being flushed.
    assign q_pop      = inst_valid && inst_ready && !redirect;
    assign inst_valid = (q_count != '0);

    // Next-state and request logic; kill marks the single outstanding response as stale.
    always_comb begin
        state_d   = state_q;
        kill_d    = kill_q;
        pend_pc_d = pend_pc_q;
        imem_req  = 1'b0;
        q_push    = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                imem_req = (q_count < Q_FULL);
                if (imem_req && imem_gnt) begin
                    pend_pc_d = curr_pc;
                    state_d   = WAIT;
                    if (redirect) begin
                        kill_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    q_push  = !kill_q && !redirect;
                    kill_d  = 1'b0;
                    state_d = REQ;
                end else if (redirect) begin
                    kill_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, kill flag and pending-address registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            kill_q    <= 1'b0;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            kill_q    <= kill_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    fetch_queue #(
        .AW (ISIZE),
        .DW (IWIDTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst),
        .push      (q_push),
        .push_pc   (pend_pc_q),
        .push_data (imem_rdata),
        .pop       (q_pop),
        .flush     (redirect),
        .count     (q_count),
        .head_pc   (inst_pc),
        .head_data (inst_data)
    );

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer with PC register and memory models
module tb_fetch_sequencer;

    localparam logic [15:0] DMASK = 16'hC3C3;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] curr_pc, next_pc, imem_addr, redirect_pc, inst_pc;
    logic        imem_req, imem_gnt, imem_rvalid, redirect, inst_valid, inst_ready;
    logic [15:0] imem_rdata, inst_data;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] sb_q[$];
    logic [15:0] mon_e;

    int          lat  = 1;
    logic        pend = 1'b0;
    int          pcnt = 0;
    logic [15:0] paddr = '0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .curr_pc     (curr_pc),
        .next_pc     (next_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // PC register model
    always @(posedge clk or negedge rst) begin
        if (!rst) curr_pc <= '0;
        else      curr_pc <= next_pc;
    end

    // Memory model: capture a grant, answer after lat cycles with addr ^ DMASK
    always @(negedge clk) begin
        if (rst && imem_req && imem_gnt && !pend) begin
            pend  = 1'b1;
            pcnt  = lat;
            paddr = imem_addr;
        end
    end

    always @(posedge clk) begin
        #1;
        imem_rvalid = 1'b0;
        if (!rst) begin
            pend = 1'b0;
        end else if (pend) begin
            pcnt--;
            if (pcnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = paddr ^ DMASK;
                pend        = 1'b0;
            end
        end
    end

    // Monitor: every accepted head must match the oldest expected entry
    always @(negedge clk) begin
        if (rst && inst_valid && inst_ready && !redirect) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_delivery: got pc %h want none", inst_pc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("deliver_pc", inst_pc, mon_e);
                chk("deliver_data", inst_data, mon_e ^ DMASK);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input logic [15:0] a, input int budget);
        bit          got = 1'b0;
        logic [15:0] an;
        an = a + 16'd1;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (imem_req && imem_gnt) begin
                got = 1'b1;
                chk("grant_addr", imem_addr, a);
                chk("grant_next_pc", next_pc, an);
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL grant_timeout: got none want addr %h", a);
        end
    endtask

    task automatic do_redirect(input logic [15:0] t);
        cyc();
        redirect    = 1'b1;
        redirect_pc = t;
        @(negedge clk);
        chk("redirect_next_pc", next_pc, t);
        cyc();
        redirect = 1'b0;
    endtask

    task automatic drain_check(input string name);
        repeat (6) @(negedge clk);
        chk(name, sb_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; imem_gnt = 1'b1; inst_ready = 1'b1; redirect = 1'b0;
        redirect_pc = '0; imem_rvalid = 1'b0; imem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_valid", inst_valid, 0);
        chk("rst_data", inst_data, 0);
        chk("rst_pc", inst_pc, 0);

        // reset release, streaming fetch
        sb_q.push_back(16'h0000); sb_q.push_back(16'h0001); sb_q.push_back(16'h0002);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_req", imem_req, 0);
        @(negedge clk);
        chk("first_req", imem_req, 1);
        chk("first_addr", imem_addr, 16'h0000);
        chk("first_next_pc", next_pc, 16'h0001);
        wait_grant(16'h0001, 6);
        wait_grant(16'h0002, 6);
        cyc(); imem_gnt = 1'b0;
        drain_check("t1_drained");

        // backpressure
        cyc(); inst_ready = 1'b0;
        do_redirect(16'h0000);
        imem_gnt = 1'b1;
        sb_q.push_back(16'h0000); sb_q.push_back(16'h0001); sb_q.push_back(16'h0002);
        wait_grant(16'h0000, 4);
        wait_grant(16'h0001, 6);
        repeat (6) @(negedge clk);
        chk("bp_full_req", imem_req, 0);
        chk("bp_valid", inst_valid, 1);
        chk("bp_head_pc", inst_pc, 16'h0000);
        cyc(); inst_ready = 1'b1;
        cyc(); inst_ready = 1'b0;
        wait_grant(16'h0002, 4);
        cyc(); imem_gnt = 1'b0; inst_ready = 1'b1;
        drain_check("t2_drained");

        // redirect while a response is outstanding
        cyc(); inst_ready = 1'b0;
        do_redirect(16'h0004);
        imem_gnt = 1'b1;
        wait_grant(16'h0004, 4);
        cyc(); lat = 3;
        wait_grant(16'h0005, 4);
        cyc(); redirect = 1'b1; redirect_pc = 16'h0040;
        @(negedge clk);
        chk("t3_next_pc", next_pc, 16'h0040);
        chk("t3_wait_req", imem_req, 0);
        chk("t3_pre_flush_valid", inst_valid, 1);
        cyc(); redirect = 1'b0; inst_ready = 1'b1; lat = 1;
        @(negedge clk);
        chk("t3_flushed", inst_valid, 0);
        wait_grant(16'h0040, 8);
        sb_q.push_back(16'h0040);
        cyc(); imem_gnt = 1'b0;
        drain_check("t3_drained");

        // redirect in the grant cycle
        do_redirect(16'h0010);
        redirect = 1'b1; redirect_pc = 16'h0080; imem_gnt = 1'b1;
        @(negedge clk);
        chk("t4_req", imem_req, 1);
        chk("t4_addr", imem_addr, 16'h0010);
        chk("t4_next_pc", next_pc, 16'h0080);
        cyc(); redirect = 1'b0;
        wait_grant(16'h0080, 8);
        sb_q.push_back(16'h0080);
        cyc(); imem_gnt = 1'b0;
        drain_check("t4_drained");

        // wrap-around
        do_redirect(16'hFFFF);
        imem_gnt = 1'b1;
        @(negedge clk);
        chk("t5_req", imem_req, 1);
        chk("t5_addr", imem_addr, 16'hFFFF);
        chk("t5_next_pc", next_pc, 16'h0000);
        sb_q.push_back(16'hFFFF);
        cyc(); imem_gnt = 1'b0;
        drain_check("t5_drained");
        chk("t5_pc_after_wrap", next_pc, 16'h0000);

        // async reset while waiting with a buffered entry
        cyc(); inst_ready = 1'b0;
        do_redirect(16'h0020);
        imem_gnt = 1'b1;
        wait_grant(16'h0020, 4);
        cyc(); lat = 3;
        wait_grant(16'h0021, 4);
        cyc();
        chk("t6_pre_valid", inst_valid, 1);
        chk("t6_pre_req", imem_req, 0);
        #1 rst = 1'b0;
        #1;
        chk("t6_async_req", imem_req, 0);
        chk("t6_async_valid", inst_valid, 0);
        chk("t6_async_data", inst_data, 0);
        chk("t6_async_pc", inst_pc, 0);
        chk("t6_async_next_pc", next_pc, 0);
        imem_gnt = 1'b0; inst_ready = 1'b1; lat = 1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("t6_idle_req", imem_req, 0);
        @(negedge clk);
        chk("t6_req", imem_req, 1);
        chk("t6_addr", imem_addr, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t6_no_stale", inst_valid, 0);
        end
        chk("final_sb_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
